// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the load/store unit:
//   XLEN_DEFAULT  default data/address width
//   MEM_B/H/W     decoder access-size encodings (2'b11 is handled as word)
//   lsu_state_t   bus-controller FSM states
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the LSU.
// Store side (driven from the live request):
//   reqSize, reqOffset, storeData -> byteEn, laneData, misaligned
// Load side (driven from the registered access attributes):
//   rdSize, rdUnsigned, rdOffset, busWord -> loadData (extracted + extended)
// Size 2'b11 behaves as a word access.
// ---------------------------------------------------------------------------
module lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [1:0]      reqSize,
    input  logic [1:0]      reqOffset,
    input  logic [XLEN-1:0] storeData,
    output logic [3:0]      byteEn,
    output logic [XLEN-1:0] laneData,
    output logic            misaligned,
    input  logic [1:0]      rdSize,
    input  logic            rdUnsigned,
    input  logic [1:0]      rdOffset,
    input  logic [XLEN-1:0] busWord,
    output logic [XLEN-1:0] loadData
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        byteEn     = 4'b1111;
        laneData   = storeData;
        misaligned = 1'b0;
        case (reqSize)
            MEM_B: begin
                byteEn   = 4'b0001 << reqOffset;
                laneData = {(XLEN/8){storeData[7:0]}};
            end
            MEM_H: begin
                byteEn     = 4'b0011 << {reqOffset[1], 1'b0};
                laneData   = {(XLEN/16){storeData[15:0]}};
                misaligned = reqOffset[0];
            end
            default: begin
                byteEn     = 4'b1111;
                laneData   = storeData;
                misaligned = (reqOffset != 2'b00);
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0 before truncating.
    always_comb begin
        shifted  = busWord >> {rdOffset, 3'b000};
        loadData = shifted;
        case (rdSize)
            MEM_B:   loadData = {{(XLEN-8){~rdUnsigned & shifted[7]}}, shifted[7:0]};
            MEM_H:   loadData = {{(XLEN-16){~rdUnsigned & shifted[15]}}, shifted[15:0]};
            default: loadData = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_bus_ctrl
// Sequences execute-stage loads/stores onto a single-outstanding req/ack bus.
//   clk, rst_n                  clock, asynchronous active-low reset
//   ld_req, st_req              access requests (store wins if both high)
//   mem_size, ld_unsigned       access size (00 B, 01 H, 10/11 W), zero-extend
//   addr, wdata                 byte address, right-justified store data
//   bus_req/we/addr/be/wdata    bus request side, held stable while in BUS
//   bus_ack, bus_rdata          bus completion and read word
//   stall                       holds the pipeline while an access is pending
//   rdata_valid, rdata          load result pulse and held load result
//   misalign_fault              pulse for a misaligned access (never on bus)
//   bus_timeout                 pulse when an ack never arrives
// Optional build macro LSU_TIMEOUT_EN enables the ack-wait limit
// TIMEOUT_CYCLES; without it BUS waits forever and bus_timeout is 0.
// ---------------------------------------------------------------------------
module lsu_bus_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_req,
    input  logic            st_req,
    input  logic [1:0]      mem_size,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            stall,
    output logic            rdata_valid,
    output logic [XLEN-1:0] rdata,
    output logic            misalign_fault,
    output logic            bus_timeout
);

    // Four byte lanes are assumed throughout; the wait limit must be usable.
    if (XLEN != 32) begin : g_badXlen
        $error("lsu_bus_ctrl: XLEN must be 32");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
        $error("lsu_bus_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_t      stateReg, stateNext;
    logic [XLEN-1:0] busAddrReg, busWdataReg, rdataReg;
    logic [3:0]      busBeReg;
    logic            busWeReg;
    logic [1:0]      sizeReg, offsetReg;
    logic            unsignedReg, isLoadReg, faultReg, timeoutReg;

    logic            req;
    logic            timeoutHit;
    logic [3:0]      alignBe;
    logic [XLEN-1:0] alignWdata, alignRdata;
    logic            alignMis;

    assign req = ld_req | st_req;

    lsu_align #(.XLEN(XLEN)) u_align (
        .reqSize    (mem_size),
        .reqOffset  (addr[1:0]),
        .storeData  (wdata),
        .byteEn     (alignBe),
        .laneData   (alignWdata),
        .misaligned (alignMis),
        .rdSize     (sizeReg),
        .rdUnsigned (unsignedReg),
        .rdOffset   (offsetReg),
        .busWord    (bus_rdata),
        .loadData   (alignRdata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] waitCntReg;

    // Holding the counter at zero while idle clears it on every entry to BUS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCntReg <= '0;
        end else if (stateReg == IDLE) begin
            waitCntReg <= '0;
        end else if ((stateReg == BUS) && !bus_ack) begin
            waitCntReg <= waitCntReg + CNT_W'(1);
        end
    end

    // Fires during the last permitted wait cycle, so the count reaches the
    // limit on the same edge that leaves BUS.
    assign timeoutHit = (waitCntReg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (req) begin
                    stateNext = alignMis ? DONE : BUS;
                end
            end
            BUS: begin
                if (bus_ack || timeoutHit) begin
                    stateNext = DONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            busAddrReg  <= '0;
            busWdataReg <= '0;
            busBeReg    <= '0;
            busWeReg    <= 1'b0;
            sizeReg     <= '0;
            offsetReg   <= '0;
            unsignedReg <= 1'b0;
            isLoadReg   <= 1'b0;
            faultReg    <= 1'b0;
            timeoutReg  <= 1'b0;
            rdataReg    <= '0;
        end else begin
            stateReg <= stateNext;
            case (stateReg)
                IDLE: begin
                    if (req) begin
                        faultReg   <= alignMis;
                        timeoutReg <= 1'b0;
                        isLoadReg  <= ~st_req;
                        // A misaligned access leaves the bus registers untouched.
                        if (!alignMis) begin
                            busAddrReg  <= {addr[XLEN-1:2], 2'b00};
                            busBeReg    <= alignBe;
                            busWdataReg <= alignWdata;
                            busWeReg    <= st_req;
                            sizeReg     <= mem_size;
                            unsignedReg <= ld_unsigned;
                            offsetReg   <= addr[1:0];
                        end
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        if (isLoadReg) begin
                            rdataReg <= alignRdata;
                        end
                    end else if (timeoutHit) begin
                        timeoutReg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_req     = (stateReg == BUS);
    assign bus_we      = busWeReg;
    assign bus_addr    = busAddrReg;
    assign bus_be      = busBeReg;
    assign bus_wdata   = busWdataReg;
    assign stall       = ((stateReg == IDLE) & req) | (stateReg == BUS);
    assign rdata       = rdataReg;
    assign rdata_valid = (stateReg == DONE) & isLoadReg & ~faultReg & ~timeoutReg;
    assign misalign_fault = (stateReg == DONE) & faultReg;
`ifdef LSU_TIMEOUT_EN
    assign bus_timeout = (stateReg == DONE) & timeoutReg;
`else
    assign bus_timeout = 1'b0;
`endif

endmodule
